// File: rtl/ir_seq_ctrl.sv
// Instruction sequencer: fetches 8-bit instructions, strobes the IR load, and
// issues single-cycle datapath / data-memory control pulses per opcode.
module ir_seq_ctrl #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            start,
    input  logic [7:0]      ir_out,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_valid,
    input  logic            dmem_ready,
    input  logic            z_flag,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic            ir_ld,
    output logic [2:0]      alu_op,
    output logic            ac_we,
    output logic            dmem_rd,
    output logic            dmem_wr,
    output logic            busy,
    output logic            halted
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDI   = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_INC   = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'hF);

    localparam logic [2:0] ALU_IMM = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_INC = 3'd3;
    localparam logic [2:0] ALU_MEM = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_OPND,
        S_HALT
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [OP_W-1:0] op_q, op_nxt;
    logic [OP_W-1:0] dec_op;
    logic            imm_unused;

    // The immediate is consumed by the datapath, not by the sequencer.
    assign dec_op     = ir_out[7:4];
    assign imm_unused = ^ir_out[3:0];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            pc    <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            op_q  <= op_nxt;
        end
    end

    // Next state plus state-decoded control; the opcode is latched in DECODE.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        op_nxt    = op_q;
        imem_req  = 1'b0;
        ir_ld     = 1'b0;
        alu_op    = ALU_IMM;
        ac_we     = 1'b0;
        dmem_rd   = 1'b0;
        dmem_wr   = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_ld     = 1'b1;
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                op_nxt = dec_op;
                case (dec_op)
                    OP_LDI, OP_ADD, OP_SUB, OP_INC: state_nxt = S_EXEC;
                    OP_LOAD, OP_STORE:              state_nxt = S_MEM;
                    OP_JMP, OP_JZ:                  state_nxt = S_OPND;
                    OP_HALT:                        state_nxt = S_HALT;
                    default:                        state_nxt = S_FETCH;
                endcase
            end
            S_EXEC: begin
                ac_we     = 1'b1;
                state_nxt = S_FETCH;
                case (op_q)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_INC:  alu_op = ALU_INC;
                    default: alu_op = ALU_IMM;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LOAD) begin
                    dmem_rd = 1'b1;
                end else begin
                    dmem_wr = 1'b1;
                end
                if (dmem_ready) begin
                    state_nxt = S_FETCH;
                    if (op_q == OP_LOAD) begin
                        ac_we  = 1'b1;
                        alu_op = ALU_MEM;
                    end
                end
            end
            S_OPND: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    state_nxt = S_FETCH;
                    if ((op_q == OP_JMP) || z_flag) begin
                        pc_nxt = PC_W'(imem_rdata);
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                    end
                end
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
